// File: rtl/mpeg_word_packer.sv
// -----------------------------------------------------------------------------
// mpeg_word_packer
//
// Read-side drain for the MPEG output byte FIFO. Pops bytes (1-cycle read
// latency), packs them big-endian into 32-bit words and presents them on a
// valid/ready interface. At end of stream any partial word is flushed with a
// byte-keep mask and a last flag, after which done is raised.
//
// Ports:
//   clk, rst_n     system clock, asynchronous active-low reset
//   fifo_dout      FIFO read data, valid the cycle after fifo_rd
//   fifo_empty     FIFO empty flag
//   fifo_rd        FIFO pop strobe (combinational)
//   stream_end     sticky level: no more bytes will enter the FIFO
//   out_data       packed word, first byte in [31:24]
//   out_keep       byte-valid mask, keep[3] covers [31:24]
//   out_last       marks the final partial word
//   out_valid      word valid
//   out_ready      downstream accept
//   byte_cnt       bytes captured (wraps)
//   word_cnt       words accepted downstream (wraps)
//   done           sticky, flush complete
//   err_late_data  sticky, FIFO went non-empty after done
// -----------------------------------------------------------------------------
module mpeg_word_packer #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       fifo_dout,
  input  logic             fifo_empty,
  output logic             fifo_rd,
  input  logic             stream_end,
  output logic [31:0]      out_data,
  output logic [3:0]       out_keep,
  output logic             out_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] byte_cnt,
  output logic [CNT_W-1:0] word_cnt,
  output logic             done,
  output logic             err_late_data
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [1:0]       r_cnt;       // next byte slot, 0 = [31:24]
  logic [31:0]      r_acc;       // word under assembly, or the skid word
  logic             r_acc_full;  // r_acc holds a complete word waiting
  logic             r_rd_d;      // a byte arrives on fifo_dout this cycle

  logic [31:0]      r_out_data;
  logic [3:0]       r_out_keep;
  logic             r_out_last;
  logic             r_out_valid;
  logic [CNT_W-1:0] r_byte_cnt;
  logic [CNT_W-1:0] r_word_cnt;
  logic             r_done;
  logic             r_err_late;

  logic             w_out_free;
  logic             w_word_done;
  logic             w_skid_stall;
  logic             w_direct_load;
  logic             w_drain_load;
  logic             w_flush_load;
  logic             w_fifo_rd;

  // MSB-first keep mask for a partial word of n bytes.
  function automatic logic [3:0] partial_keep(input logic [1:0] n);
    case (n)
      2'd1:    return 4'b1000;
      2'd2:    return 4'b1100;
      2'd3:    return 4'b1110;
      default: return 4'b0000;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Control: read strobe, load selection, next state
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path can
    // leave one unassigned, which would otherwise infer a latch.
    w_state_nxt   = r_state;
    w_out_free    = ~r_out_valid | out_ready;
    w_word_done   = r_rd_d & (r_cnt == 2'd3);
    // A word completes now but the output register cannot take it; it goes to
    // the skid, so the byte that a read issued now would return has no home.
    w_skid_stall  = w_word_done & ~w_out_free;
    // Gated with rst_n so no pop is issued while reset is held.
    w_fifo_rd     = rst_n & (r_state == ST_RUN) & ~fifo_empty & ~r_acc_full
                    & ~w_skid_stall;
    w_direct_load = w_word_done & w_out_free;
    w_drain_load  = r_acc_full & w_out_free;
    w_flush_load  = (r_state == ST_FLUSH) & (r_cnt != 2'd0) & w_out_free;

    case (r_state)
      ST_RUN: begin
        if (stream_end & fifo_empty & ~r_rd_d & ~w_fifo_rd & ~r_acc_full)
          w_state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        if ((r_cnt == 2'd0) & ~r_out_valid)
          w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_state_nxt = ST_DONE;
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
    end else begin
      // NOTE: sequential state is updated with non-blocking assignments so
      // every flop samples pre-edge values regardless of statement order.
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath: byte capture, skid, output register, counters, status
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= 2'd0;
      r_acc       <= 32'h0;
      r_acc_full  <= 1'b0;
      r_rd_d      <= 1'b0;
      r_out_data  <= 32'h0;
      r_out_keep  <= 4'h0;
      r_out_last  <= 1'b0;
      r_out_valid <= 1'b0;
      r_byte_cnt  <= '0;
      r_word_cnt  <= '0;
      r_done      <= 1'b0;
      r_err_late  <= 1'b0;
    end else begin
      r_rd_d <= w_fifo_rd;

      // Byte capture. Slot 0 clears the low bytes so that a flushed partial
      // word carries zeros in its unused slots.
      if (r_rd_d) begin
        r_byte_cnt <= r_byte_cnt + CNT_W'(1);
        r_cnt      <= r_cnt + 2'd1;
        case (r_cnt)
          2'd0: r_acc <= {fifo_dout, 24'h0};
          2'd1: r_acc[23:16] <= fifo_dout;
          2'd2: r_acc[15:8]  <= fifo_dout;
          default: begin
            if (!w_out_free) begin
              r_acc      <= {r_acc[31:8], fifo_dout};
              r_acc_full <= 1'b1;
            end
          end
        endcase
      end

      // Captures are blocked while the skid is full, so the drain never
      // collides with a write of r_acc above.
      if (w_drain_load)
        r_acc_full <= 1'b0;

      // Flush and capture never coincide: no reads are issued outside RUN.
      if (w_flush_load)
        r_cnt <= 2'd0;

      // Output register. At most one load source is active in any cycle.
      if (w_direct_load) begin
        r_out_data  <= {r_acc[31:8], fifo_dout};
        r_out_keep  <= 4'b1111;
        r_out_last  <= 1'b0;
        r_out_valid <= 1'b1;
      end else if (w_drain_load) begin
        r_out_data  <= r_acc;
        r_out_keep  <= 4'b1111;
        r_out_last  <= 1'b0;
        r_out_valid <= 1'b1;
      end else if (w_flush_load) begin
        r_out_data  <= r_acc;
        r_out_keep  <= partial_keep(r_cnt);
        r_out_last  <= 1'b1;
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end

      if (r_out_valid & out_ready)
        r_word_cnt <= r_word_cnt + CNT_W'(1);

      if (w_state_nxt == ST_DONE)
        r_done <= 1'b1;

      if ((r_state == ST_DONE) & ~fifo_empty)
        r_err_late <= 1'b1;
    end
  end

  assign fifo_rd       = w_fifo_rd;
  assign out_data      = r_out_data;
  assign out_keep      = r_out_keep;
  assign out_last      = r_out_last;
  assign out_valid     = r_out_valid;
  assign byte_cnt      = r_byte_cnt;
  assign word_cnt      = r_word_cnt;
  assign done          = r_done;
  assign err_late_data = r_err_late;

endmodule

// File: tb/tb_mpeg_word_packer.sv
// -----------------------------------------------------------------------------
// tb_mpeg_word_packer
//
// Scoreboard bench: stimulus loads bytes into a FIFO model and pushes the
// hand-computed words it expects; a forked monitor compares every accepted
// output word against the head of that queue.
// -----------------------------------------------------------------------------
module tb_mpeg_word_packer;

  localparam int CNT_W = 32;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } word_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [7:0]       fifo_dout;
  logic             fifo_empty;
  logic             fifo_rd;
  logic             stream_end;
  logic [31:0]      out_data;
  logic [3:0]       out_keep;
  logic             out_last;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] byte_cnt;
  logic [CNT_W-1:0] word_cnt;
  logic             done;
  logic             err_late_data;

  int n_vec  = 0;
  int n_fail = 0;

  word_t exp_q[$];

  // FIFO model: written by stimulus, popped by the 1-cycle-latency read port.
  logic [7:0] fifo_mem [0:255];
  logic [7:0] wr_ptr = 8'd0;
  logic [7:0] rd_ptr = 8'd0;
  logic       fifo_flush = 1'b0;

  always #5 clk = ~clk;

  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_flush) begin
      rd_ptr <= wr_ptr;
    end else if (fifo_rd) begin
      fifo_dout <= fifo_mem[rd_ptr];
      rd_ptr    <= rd_ptr + 8'd1;
    end
  end

  mpeg_word_packer #(.CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fifo_dout     (fifo_dout),
    .fifo_empty    (fifo_empty),
    .fifo_rd       (fifo_rd),
    .stream_end    (stream_end),
    .out_data      (out_data),
    .out_keep      (out_keep),
    .out_last      (out_last),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .byte_cnt      (byte_cnt),
    .word_cnt      (word_cnt),
    .done          (done),
    .err_late_data (err_late_data)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    fifo_mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  task automatic expect_word(input logic [31:0] d, input logic [3:0] k, input logic l);
    word_t w;
    w.data = d;
    w.keep = k;
    w.last = l;
    exp_q.push_back(w);
  endtask

  // Enter reset and discard anything left in the FIFO model.
  task automatic enter_reset();
    @(negedge clk);
    rst_n      = 1'b0;
    stream_end = 1'b0;
    fifo_flush = 1'b1;
    @(negedge clk);
    fifo_flush = 1'b0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_done(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (done) break;
    end
    check(name, {63'h0, done}, 64'h1);
  endtask

  // Monitor: compares each word the DUT hands over on valid & ready. Sampled
  // after stimulus settles at the negedge, well before the next posedge.
  task automatic monitor();
    word_t got;
    word_t want;
    forever begin
      @(negedge clk);
      #3;
      if (rst_n && out_valid && out_ready) begin
        got.data = out_data;
        got.keep = out_keep;
        got.last = out_last;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL unexpected_word: got data=%08h keep=%b last=%b, expected no word",
                   out_data, out_keep, out_last);
        end else begin
          want = exp_q.pop_front();
          check("word", 64'(got), 64'(want));
        end
      end
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b [0:3];
    int rd_high, rd_first, rd_last;

    rst_n      = 1'b0;
    stream_end = 1'b0;
    out_ready  = 1'b1;
    fifo_dout  = 8'h0;

    fork
      monitor();
    join_none

    // ---- 8 bytes, stream_end already high --------------------------------
    enter_reset();
    for (int i = 1; i <= 8; i++) push(8'(i));
    stream_end = 1'b1;
    expect_word(32'h01020304, 4'hF, 1'b0);
    expect_word(32'h05060708, 4'hF, 1'b0);
    #1;
    check("reset_fifo_rd", {63'h0, fifo_rd}, 64'h0);
    check("reset_outputs", {out_data, out_keep, out_last, out_valid, done, err_late_data},
          64'h0);
    check("reset_counts", {byte_cnt, word_cnt}, 64'h0);
    release_reset();
    wait_done("t8_done", 200);
    check("t8_byte_cnt", 64'(byte_cnt), 64'd8);
    check("t8_word_cnt", 64'(word_cnt), 64'd2);
    check("t8_sb_drained", 64'(exp_q.size()), 64'd0);

    // ---- 6 bytes: partial flush keep=1100, then late data -----------------
    enter_reset();
    for (int i = 0; i < 6; i++) push(8'hAA + 8'(i));
    stream_end = 1'b1;
    expect_word(32'hAAABACAD, 4'hF, 1'b0);
    expect_word(32'hAEAF0000, 4'hC, 1'b1);
    release_reset();
    wait_done("t6_done", 200);
    check("t6_word_cnt", 64'(word_cnt), 64'd2);
    check("t6_sb_drained", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    push(8'h5A);
    repeat (3) begin
      @(negedge clk);
      #1;
      check("late_fifo_rd", {63'h0, fifo_rd}, 64'h0);
    end
    check("late_err", {63'h0, err_late_data}, 64'h1);
    check("late_byte_cnt", 64'(byte_cnt), 64'd6);

    // ---- 3 bytes -> keep 1110; 5 bytes -> keep 1000 ----------------------
    enter_reset();
    push(8'hC1); push(8'hC2); push(8'hC3);
    stream_end = 1'b1;
    expect_word(32'hC1C2C300, 4'hE, 1'b1);
    release_reset();
    wait_done("t3_done", 200);
    check("t3_word_cnt", 64'(word_cnt), 64'd1);
    check("t3_err_clear", {63'h0, err_late_data}, 64'h0);

    enter_reset();
    for (int i = 0; i < 5; i++) push(8'hD0 + 8'(i));
    stream_end = 1'b1;
    expect_word(32'hD0D1D2D3, 4'hF, 1'b0);
    expect_word(32'hD4000000, 4'h8, 1'b1);
    release_reset();
    wait_done("t5_done", 200);
    check("t5_byte_cnt", 64'(byte_cnt), 64'd5);

    // ---- 64 bytes continuous ---------------------------------------------
    enter_reset();
    for (int i = 0; i < 64; i++) push(8'(i) + 8'h80);
    for (int w = 0; w < 16; w++) begin
      for (int k = 0; k < 4; k++) b[k] = 8'h80 + 8'(4 * w + k);
      expect_word({b[0], b[1], b[2], b[3]}, 4'hF, 1'b0);
    end
    release_reset();
    rd_high  = 0;
    rd_first = -1;
    rd_last  = -1;
    for (int c = 0; c < 80; c++) begin
      #1;
      if (fifo_rd) begin
        rd_high++;
        if (rd_first < 0) rd_first = c;
        rd_last = c;
      end
      @(negedge clk);
    end
    check("stream_rd_cycles", 64'(rd_high), 64'd64);
    check("stream_rd_span", 64'(rd_last - rd_first + 1), 64'd64);
    check("stream_word_cnt", 64'(word_cnt), 64'd16);
    stream_end = 1'b1;
    wait_done("stream_done", 50);
    check("stream_sb_drained", 64'(exp_q.size()), 64'd0);

    // ---- out_ready stall: skid holds the second word ----------------------
    enter_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 12; i++) push(8'h10 + 8'(i));
    expect_word(32'h10111213, 4'hF, 1'b0);
    expect_word(32'h14151617, 4'hF, 1'b0);
    expect_word(32'h18191A1B, 4'hF, 1'b0);
    release_reset();
    repeat (20) @(negedge clk);
    #1;
    check("stall_byte_cnt", 64'(byte_cnt), 64'd8);
    check("stall_fifo_rd", {63'h0, fifo_rd}, 64'h0);
    check("stall_out_hold", {out_data, out_keep, out_last, out_valid}, {32'h10111213, 4'hF, 1'b0, 1'b1});
    out_ready  = 1'b1;
    stream_end = 1'b1;
    wait_done("stall_done", 200);
    check("stall_word_cnt", 64'(word_cnt), 64'd3);
    check("stall_sb_drained", 64'(exp_q.size()), 64'd0);

    // ---- reset mid-word ---------------------------------------------------
    enter_reset();
    push(8'h11); push(8'h22);
    release_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (byte_cnt == 2) break;
    end
    check("midrst_captured", 64'(byte_cnt), 64'd2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_outputs", {out_data, out_keep, out_last, out_valid, done, err_late_data},
          64'h0);
    check("midrst_counts", {byte_cnt, word_cnt}, 64'h0);
    push(8'h33); push(8'h44); push(8'h55); push(8'h66);
    stream_end = 1'b1;
    expect_word(32'h33445566, 4'hF, 1'b0);
    release_reset();
    wait_done("midrst_done", 200);
    check("midrst_word_cnt", 64'(word_cnt), 64'd1);
    check("midrst_byte_cnt", 64'(byte_cnt), 64'd4);
    check("midrst_sb_drained", 64'(exp_q.size()), 64'd0);

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
